// File: rtl/fft_input_loader.sv
// fft_input_loader
//   Input stage of the 32-point FFT. Serial complex samples arrive on a
//   valid/ready stream and are stored in bit-reversed slot order. Once 32
//   samples are collected the frame is presented in parallel on out0..out31
//   and held until the consumer acknowledges it with frame_ready.
//
// Parameters
//   FRAC  fractional bits per real/imag half (format metadata only, data is
//         stored bit-exact)
//   BITS  width of each real/imag half; a complex word is 2*BITS wide
//
// Ports
//   clk_100      rising-edge clock
//   reset        asynchronous, active-low reset
//   in_data      sample {imag, real}
//   in_valid     in_data valid
//   in_ready     loader accepts in_data this cycle
//   flush        synchronous discard of the partially filled frame
//   frame_valid  out0..out31 hold a complete frame
//   frame_ready  consumer takes the presented frame at this edge
//   sample_cnt   samples accepted into the frame being filled
//   out0..out31  parallel frame, outj = sample number bitrev5(j)
//
// Build option
//   PINGPONG_EN  when defined, a second bank lets filling continue while a
//                frame is presented; otherwise FILL/HOLD single-bank flow.
module fft_input_loader #(
  parameter int unsigned FRAC = 7,
  parameter int unsigned BITS = 16
) (
  input  logic              clk_100,
  input  logic              reset,
  input  logic [2*BITS-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [4:0]        sample_cnt,
  output logic [2*BITS-1:0] out0,
  output logic [2*BITS-1:0] out1,
  output logic [2*BITS-1:0] out2,
  output logic [2*BITS-1:0] out3,
  output logic [2*BITS-1:0] out4,
  output logic [2*BITS-1:0] out5,
  output logic [2*BITS-1:0] out6,
  output logic [2*BITS-1:0] out7,
  output logic [2*BITS-1:0] out8,
  output logic [2*BITS-1:0] out9,
  output logic [2*BITS-1:0] out10,
  output logic [2*BITS-1:0] out11,
  output logic [2*BITS-1:0] out12,
  output logic [2*BITS-1:0] out13,
  output logic [2*BITS-1:0] out14,
  output logic [2*BITS-1:0] out15,
  output logic [2*BITS-1:0] out16,
  output logic [2*BITS-1:0] out17,
  output logic [2*BITS-1:0] out18,
  output logic [2*BITS-1:0] out19,
  output logic [2*BITS-1:0] out20,
  output logic [2*BITS-1:0] out21,
  output logic [2*BITS-1:0] out22,
  output logic [2*BITS-1:0] out23,
  output logic [2*BITS-1:0] out24,
  output logic [2*BITS-1:0] out25,
  output logic [2*BITS-1:0] out26,
  output logic [2*BITS-1:0] out27,
  output logic [2*BITS-1:0] out28,
  output logic [2*BITS-1:0] out29,
  output logic [2*BITS-1:0] out30,
  output logic [2*BITS-1:0] out31
);

  // FRAC only documents the Q format; a fractional field wider than the
  // word has no meaning, this empty block just names that condition.
  if (FRAC > BITS) begin : g_frac_wider_than_word
  end

  typedef logic [2*BITS-1:0] word_t;

  // S_FILL : nothing presented, filling
  // S_HOLD : frame presented (fill bank free in ping-pong builds)
  // S_FULL : frame presented and the fill bank is complete, waiting (ping-pong)
  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_HOLD = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  word_t      bank_q [0:31];
  word_t      bank_d [0:31];
  word_t      out_q  [0:31];
  word_t      out_d  [0:31];

  logic accept;
  logic last;
  logic rel;

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

`ifdef PINGPONG_EN
  assign in_ready = (state_q != S_FULL);
`else
  assign in_ready = (state_q == S_FILL);
`endif

  assign frame_valid = (state_q != S_FILL);
  assign sample_cnt  = cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    out_d   = out_q;
    rel     = frame_valid && frame_ready;
    accept  = in_valid && in_ready && !flush;
    last    = accept && (cnt_q == 5'd31);

    if (flush) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d                  = cnt_q + 5'd1;
      bank_d[bitrev5(cnt_q)] = in_data;
    end

    case (state_q)
      S_FILL: begin
        // bank_d already carries the 32nd sample, so the copy is complete
        if (last) begin
          out_d   = bank_d;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
`ifdef PINGPONG_EN
        // Completion coinciding with a release swaps banks and keeps
        // frame_valid high; otherwise the finished bank waits in S_FULL.
        if (last) begin
          if (rel) out_d = bank_d;
          else     state_d = S_FULL;
        end else if (rel) begin
          state_d = S_FILL;
        end
`else
        if (rel) state_d = S_FILL;
`endif
      end
      S_FULL: begin
        if (rel) begin
          out_d   = bank_q;
          state_d = S_HOLD;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        bank_q[i] <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      out_q   <= out_d;
    end
  end

  assign out0  = out_q[0];
  assign out1  = out_q[1];
  assign out2  = out_q[2];
  assign out3  = out_q[3];
  assign out4  = out_q[4];
  assign out5  = out_q[5];
  assign out6  = out_q[6];
  assign out7  = out_q[7];
  assign out8  = out_q[8];
  assign out9  = out_q[9];
  assign out10 = out_q[10];
  assign out11 = out_q[11];
  assign out12 = out_q[12];
  assign out13 = out_q[13];
  assign out14 = out_q[14];
  assign out15 = out_q[15];
  assign out16 = out_q[16];
  assign out17 = out_q[17];
  assign out18 = out_q[18];
  assign out19 = out_q[19];
  assign out20 = out_q[20];
  assign out21 = out_q[21];
  assign out22 = out_q[22];
  assign out23 = out_q[23];
  assign out24 = out_q[24];
  assign out25 = out_q[25];
  assign out26 = out_q[26];
  assign out27 = out_q[27];
  assign out28 = out_q[28];
  assign out29 = out_q[29];
  assign out30 = out_q[30];
  assign out31 = out_q[31];

endmodule
